// File: rtl/stream_mux_rr_if.sv
// Stream mux bundle: N producer lanes in, one registered consumer lane out.
// slave modport is the mux side, master modport is the producer/consumer side.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          address;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic                      out_last;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    modport slave (
        input  mode, address, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_chan
    );

    modport master (
        output mode, address, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_chan
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 packet-atomic stream mux (fixed address or round-robin), one output register stage, latency 1.
// Backpressure: out_ready combinationally gates in_ready; a stalled full output register holds and blocks all inputs.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_rr_if.slave  bus
);
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] lock_chan;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (state == ST_LOCK) begin
            grant = lock_chan;
            for (int i = 0; i < CHANNELS; i++) begin
                if (lock_chan == SEL_W'(i)) grant_valid = bus.in_valid[i];
            end
        end else if (!bus.mode) begin
            // Out-of-range addresses match no lane and so never grant.
            grant = bus.address;
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.address == SEL_W'(i)) grant_valid = bus.in_valid[i];
            end
        end else begin
            grant_valid = |bus.in_valid;
            // Walk from farthest to nearest so the lane just after rr_ptr wins.
            for (int k = CHANNELS; k >= 1; k--) begin
                if (bus.in_valid[(int'(rr_ptr) + k) % CHANNELS])
                    grant = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
            end
        end
    end

    assign load = !bus.out_valid || bus.out_ready;
    assign xfer = load && grant_valid;

    always_comb begin
        bus.in_ready = '0;
        sel_data     = '0;
        sel_last     = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                bus.in_ready[i] = xfer;
                sel_data        = bus.in_data[i*WIDTH +: WIDTH];
                sel_last        = bus.in_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_chan  <= '0;
            state         <= ST_ARB;
            rr_ptr        <= SEL_W'(CHANNELS - 1);
            lock_chan     <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= xfer;
                if (xfer) begin
                    bus.out_data <= sel_data;
                    bus.out_last <= sel_last;
                    bus.out_chan <= grant;
                end
            end
            if (xfer) begin
                if (sel_last) begin
                    state  <= ST_ARB;
                    rr_ptr <= grant;
                end else if (state == ST_ARB) begin
                    state     <= ST_LOCK;
                    lock_chan <= grant;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: 4-lane instance checked by a packet-level model every cycle,
// 3-lane instance used for out-of-range address and wrap behaviour.
module tb_stream_mux_rr;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) a ();
    stream_mux_rr_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) b ();

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Packet-level model: which lane owns the output (-1 = none), last lane that finished a packet.
    int         m_lock;
    int         m_last_done;
    logic       m_ov;
    logic [7:0] m_od;
    logic       m_ol;
    int         m_oc;

    function automatic int model_pick(input logic md, input logic [1:0] adr,
                                      input logic [3:0] v, output bit ok);
        if (m_lock >= 0) begin
            ok = v[m_lock];
            return m_lock;
        end
        if (!md) begin
            ok = v[adr];
            return int'(adr);
        end
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_last_done + k) % 4]) begin
                ok = 1'b1;
                return (m_last_done + k) % 4;
            end
        end
        ok = 1'b0;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit ok;
        int g;
        if (!rst_n) begin
            m_lock = -1; m_last_done = 3;
            m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_oc = 0;
        end else if (!m_ov || a.out_ready) begin
            g = model_pick(a.mode, a.address, a.in_valid, ok);
            m_ov = ok;
            if (ok) begin
                m_od = a.in_data[g*8 +: 8];
                m_ol = a.in_last[g];
                m_oc = g;
                if (a.in_last[g]) begin
                    m_lock = -1;
                    m_last_done = g;
                end else begin
                    m_lock = g;
                end
            end
        end
    end

    bit         cmp_ok;
    int         cmp_g;
    logic [3:0] cmp_rdy;
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_g   = model_pick(a.mode, a.address, a.in_valid, cmp_ok);
            cmp_rdy = ((!m_ov || a.out_ready) && cmp_ok) ? 4'(1 << cmp_g) : 4'b0000;
            check("mdl_in_ready", a.in_ready, cmp_rdy);
            check("mdl_out_valid", a.out_valid, m_ov);
            if (m_ov) begin
                check("mdl_out_data", a.out_data, m_od);
                check("mdl_out_last", a.out_last, m_ol);
                check("mdl_out_chan", a.out_chan, m_oc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a.mode = 1'b0; a.address = 2'd0; a.in_valid = '0; a.in_last = '0; a.in_data = '0; a.out_ready = 1'b0;
        b.mode = 1'b0; b.address = 2'd0; b.in_valid = '0; b.in_last = '0; b.in_data = '0; b.out_ready = 1'b0;
        tick; tick;
        check("rst_out_valid", a.out_valid, 0);
        check("rst_out_data", a.out_data, 0);
        check("rst_out_chan", a.out_chan, 0);
        rst_n = 1'b1;

        // Round-robin, all lanes busy with single-beat packets.
        a.mode = 1'b1; a.in_valid = 4'hF; a.in_last = 4'hF;
        a.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; a.out_ready = 1'b1;
        #1 check("rr_first_ready", a.in_ready, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick;
            check("rr_chan", a.out_chan, i % 4);
            check("rr_valid", a.out_valid, 1);
        end

        // Fixed select on lane 2.
        a.mode = 1'b0; a.address = 2'd2;
        #1 check("fix_ready", a.in_ready, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("fix_data", a.out_data, 8'hA2);
            check("fix_chan", a.out_chan, 2);
        end

        // Lane 1 three-beat packet with mode/address toggles and a one-cycle valid drop.
        a.mode = 1'b1; a.in_valid = 4'b0010; a.in_last = 4'b1001; a.in_data[15:8] = 8'h11;
        tick;
        check("lock_b1_chan", a.out_chan, 1);
        check("lock_b1_data", a.out_data, 8'h11);
        a.in_valid = 4'b1011; a.in_data[15:8] = 8'h12; a.mode = 1'b0; a.address = 2'd3;
        tick;
        check("lock_b2_chan", a.out_chan, 1);
        check("lock_b2_data", a.out_data, 8'h12);
        a.in_valid = 4'b1001; a.mode = 1'b1; a.address = 2'd0;
        tick;
        check("lock_bubble", a.out_valid, 0);
        a.in_valid = 4'b1011; a.in_data[15:8] = 8'h13; a.in_last = 4'b1011;
        tick;
        check("lock_b3_chan", a.out_chan, 1);
        check("lock_b3_last", a.out_last, 1);
        a.in_valid = 4'b1001;
        tick;
        check("lock_next3", a.out_chan, 3);
        tick;
        check("lock_next0", a.out_chan, 0);

        // Back-pressure holding 0x5C for five cycles.
        a.in_valid = 4'b0001; a.in_last = 4'hF; a.in_data[7:0] = 8'h5C;
        tick;
        check("bp_load", a.out_data, 8'h5C);
        a.out_ready = 1'b0; a.in_data[7:0] = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_hold_data", a.out_data, 8'h5C);
            check("bp_hold_valid", a.out_valid, 1);
            check("bp_ready_low", a.in_ready, 4'b0000);
        end
        a.out_ready = 1'b1;
        #1 check("bp_release_ready", a.in_ready, 4'b0001);
        tick;
        check("bp_next_beat", a.out_data, 8'h77);

        // Asynchronous reset while locked with a full output register.
        a.in_valid = 4'b0100; a.in_last = 4'h0; a.in_data[23:16] = 8'h42;
        tick;
        check("pre_rst_chan", a.out_chan, 2);
        check("pre_rst_valid", a.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", a.out_valid, 0);
        check("arst_out_data", a.out_data, 0);
        check("arst_out_last", a.out_last, 0);
        check("arst_out_chan", a.out_chan, 0);
        a.in_valid = 4'hF; a.in_last = 4'hF; a.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick;
        rst_n = 1'b1;
        #1 check("post_rst_ready", a.in_ready, 4'b0001);
        tick;
        check("post_rst_chan", a.out_chan, 0);
        check("post_rst_data", a.out_data, 8'hA0);

        // Three-lane instance: address 3 is out of range.
        b.mode = 1'b0; b.address = 2'd3; b.in_valid = 3'b111; b.in_last = 3'b111;
        b.in_data = {8'hA2, 8'hA1, 8'hA0}; b.out_ready = 1'b1;
        #1 check("b_oob_ready", b.in_ready, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("b_oob_valid", b.out_valid, 0);
        end
        b.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("b_rr_valid", b.out_valid, 1);
            check("b_rr_chan", b.out_chan, i % 3);
        end

        tick; tick;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes. It is the next-generation channel selector after the plain 4:1 gate-level multiplexer. Selection is either fixed by an address input or round-robin across requesting channels. Packets are kept atomic through a lock state, and the output is a single pipeline register stage. It sits between multiple producer streams and one shared downstream consumer.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, address/channel-id width; must equal ceil(log2(CHANNELS))
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- mode  input  1  0 = fixed select by `address`, 1 = round-robin
- address  input  SEL_W  channel selected when mode=0
- in_valid  input  CHANNELS  per-channel valid, bit i = channel i
- in_last  input  CHANNELS  per-channel end-of-packet marker
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  per-channel ready; at most one bit high
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered beat data
- out_last  output  1  registered end-of-packet marker
- out_chan  output  SEL_W  source channel of the registered beat
- out_ready  input  1  downstream accepts the beat

## Operation
- Transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. Output transfer: out_valid && out_ready.
- Stage can load: `load = !out_valid || out_ready`. The path is combinational from out_ready to in_ready.
- in_ready[i] = load && (grant == i) && grant_valid.
- FSM states:
  - ARB:
    - mode=0: grant = address; grant_valid = in_valid[address] and address < CHANNELS.
    - mode=1: grant = the first i with in_valid[i], scanning from rr_ptr+1 upward with wrap modulo CHANNELS; grant_valid = |in_valid.
    - Transfer with in_last=0: latch grant into lock_chan and go to LOCK.
    - Transfer with in_last=1: stay in ARB.
  - LOCK:
    - grant = lock_chan; grant_valid = in_valid[lock_chan]; mode and address are ignored.
    - Transfer with in_last=1: go to ARB.
- rr_ptr updates to the granted channel only on a transfer with in_last=1, in either mode. Mode=0 traffic therefore also moves the round-robin start point.
- On load with a transfer: out_data, out_last and out_chan are taken from the granted channel, and out_valid is set to 1.
- On load without a transfer: out_valid is cleared to 0 and the data registers hold their value.
- Changes to mode or address take effect only in ARB. In LOCK they are deferred until the packet ends.
- Reset values (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_last=0, out_chan=0
  - state=ARB
  - rr_ptr=CHANNELS-1, so channel 0 has first priority
  - lock_chan=0
- Reset mid-packet abandons the lock. The first beat after reset is arbitrated fresh.

## Timing
- Latency: input transfer at edge n gives out_valid=1 with that beat's data from edge n until the output transfer.
- Throughput: one beat per cycle while out_ready=1 and the granted channel is valid.
- Back-pressure: while out_valid=1 and out_ready=0, all in_ready are 0 and the output registers hold.
- Round-robin switches channel with zero bubble when the packet boundary and the next request coincide.
- If a locked channel drops in_valid, the output bubbles and no other channel is granted.
- Simultaneous requests in ARB: exactly one grant, chosen by the rules above.
- in_data, in_last and in_valid of non-granted channels have no effect on the outputs.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle, with out_valid=1 and the FSM in LOCK beforehand. Required: all outputs go to 0 immediately, with no clock edge needed. After release, all channels valid with in_last=1 and mode=1 gives first grant on channel 0.
- Fixed mode: mode=0, address=2, all channels valid with single-beat packets (in_last=1), in_data[ch]=8'hA0+ch, out_ready=1. Required: only in_ready[2] high; out_data=8'hA2 and out_chan=2 every cycle; latency 1.
- Round-robin fairness: mode=1, all 4 channels continuously valid, single-beat packets. Required: out_chan sequence 0,1,2,3,0,1,... with no idle cycles.
- Packet lock: mode=1, channel 1 sends a 3-beat packet (in_last on beat 3) while channels 0 and 3 are valid. Required: three consecutive beats with out_chan=1, then channel 3, then channel 0.
  - Toggling address or mode during the packet has no effect.
  - Dropping in_valid[1] for one cycle mid-packet produces one bubble and no interleaving.
- Back-pressure: hold out_ready=0 for 5 cycles with out_valid=1 and out_data=8'h5C. Required: out_data stable at 8'h5C, all in_ready=0. On release, the next beat follows the very next cycle.
- Boundary: CHANNELS=3, mode=0, address=3, all channels valid. Required: no grant, out_valid stays 0. Switching to mode=1 gives grants on channels 0,1,2 in order, wrapping back to 0.
